demap_frame_ctrl: RTL and testbench
===================================

DEMAP_FRAME_CTRL -- requirements
Module: demap_frame_ctrl

Interface
REQ-001 SHALL have parameter PIPE_LAT, default 6: cycles from demapper enable to demapper valid, legal range 1..15.
REQ-002 SHALL have parameter WD_CYC, default PIPE_LAT+4: drain watchdog limit in cycles.
REQ-003 SHALL use clock clk; reset rst_n, synchronous, active-low.
REQ-004 SHALL have the following ports, each given as name, direction, width and meaning:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- cfg_valid  in  1  frame-config offer.
- cfg_ready  out  1  config accept.
- cfg_mode  in  3  0 QPSK, 1 8PSK, 2 16APSK, 3 32APSK, 4 64APSK; 5-7 illegal.
- cfg_len  in  12  symbols in the frame, 1..4095.
- s_valid  in  1  upstream symbol present.
- s_ready  out  1  symbol accept.
- dm_en  out  1  demapper enable; one symbol issued.
- dm_mode  out  3  demapper Mode select.
- dm_valid  in  1  demapper result valid.
- o_llr_valid  out  1  LLR set is frame-owned.
- o_llr_last  out  1  final LLR set of the frame.
- o_nbits  out  3  valid LLR count for the current mode, 2..6.
- busy  out  1  state is not IDLE.
- err_cfg  out  1  pulse: rejected config.
- err_sync  out  1  pulse: unexpected dm_valid.
- err_timeout  out  1  pulse: drain watchdog fired.

Function
REQ-005 SHALL implement states IDLE, RUN and DRAIN.
REQ-006 IDLE SHALL drive cfg_ready=1 and s_ready=0.
REQ-007 In IDLE, cfg_valid with a legal mode and nonzero len SHALL latch mode and len, set dm_mode next cycle, and go to RUN.
REQ-008 In IDLE, cfg_valid with mode>4 or len=0 SHALL pulse err_cfg for 1 cycle, stay in IDLE, and leave dm_mode unchanged.
REQ-009 RUN SHALL drive s_ready=1 and cfg_ready=0.
REQ-010 In RUN, dm_en SHALL equal s_valid&s_ready combinationally, and each issue SHALL increment the issued counter.
REQ-011 The cycle that issues symbol number len SHALL move the FSM to DRAIN.
REQ-012 DRAIN SHALL drive s_ready=0, dm_en=0 and cfg_ready=0.
REQ-013 A 4-bit in-flight counter SHALL do +1 on dm_en and -1 on dm_valid, and stay unchanged when both occur in the same cycle.
REQ-014 o_llr_valid SHALL equal dm_valid&(inflight!=0).
REQ-015 dm_valid with inflight=0 SHALL pulse err_sync, be ignored, and leave all counters unchanged.
REQ-016 A received counter SHALL count o_llr_valid.
REQ-017 o_llr_last SHALL assert with the o_llr_valid whose received count equals len.
REQ-018 The cycle after o_llr_last the FSM SHALL be in IDLE, giving 1 bubble cycle before the next cfg accept.
REQ-019 o_llr_last MAY occur while still in RUN when PIPE_LAT=1; in that case the FSM SHALL go directly to IDLE.
REQ-020 In DRAIN, WD_CYC consecutive cycles with no dm_valid SHALL pulse err_timeout, clear all counters, and return to IDLE without asserting o_llr_last.
REQ-021 dm_mode SHALL be constant from RUN entry until IDLE is re-entered, and SHALL hold its last value in IDLE.
REQ-022 o_nbits SHALL be derived from dm_mode: 2,3,4,5,6 for modes 0..4.
REQ-023 busy SHALL be 1 in RUN and DRAIN.

Reset
REQ-024 Reset SHALL force IDLE and clear all counters.
REQ-025 Reset SHALL force dm_mode=0, dm_en=0, s_ready=0, cfg_ready=0 during reset and 1 after release, all err pulses 0, o_llr_valid=0 and o_llr_last=0.
REQ-026 Reset asserted mid-frame SHALL abandon the frame, and subsequent dm_valid SHALL raise err_sync only.

Structure
REQ-027 A shared package demap_pkg SHALL hold the mode encodings, the state enum, the MODE_MAX=4 constant and a bits-per-mode function, all reused by the demapper top.
REQ-028 No sub-module SHALL be used; the block SHALL be a single FSM plus three counters and a watchdog counter.

Verification
REQ-029 SHALL cover: cfg mode=4, len=3, s_valid held high -> dm_en high for 3 cycles, 3 o_llr_valid with o_nbits=6, o_llr_last on the 3rd, cfg_ready high one cycle later.
REQ-030 SHALL cover: cfg mode=6 or len=0 -> single err_cfg pulse, busy stays 0, dm_mode unchanged.
REQ-031 SHALL cover: len=4 with s_valid gaps of 2 cycles, and dm_valid coinciding with dm_en -> inflight never exceeds PIPE_LAT and exactly 4 LLR sets are delivered.
REQ-032 SHALL cover: a spurious dm_valid injected while in IDLE -> err_sync pulse, o_llr_valid=0.
REQ-033 SHALL cover: len=2 with the 2nd dm_valid withheld -> err_timeout after 10 cycles (default WD_CYC), FSM in IDLE, no o_llr_last.
REQ-034 SHALL cover: rst_n low for 1 cycle mid-RUN with len=100 -> all outputs at their reset values, next frame of mode=0, len=1 completes with o_nbits=2.

Source files
------------

// File: rtl/demap_pkg.sv
// Shared demapper definitions: modulation encodings, frame-controller states
// and the LLR-count-per-mode helper.
package demap_pkg;

    typedef enum logic [2:0] {
        MODE_QPSK   = 3'd0,
        MODE_8PSK   = 3'd1,
        MODE_16APSK = 3'd2,
        MODE_32APSK = 3'd3,
        MODE_64APSK = 3'd4
    } mode_e;

    localparam logic [2:0] MODE_MAX = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Number of LLRs the demapper produces per symbol in each mode.
    function automatic logic [2:0] bits_per_mode(input logic [2:0] mode);
        logic [2:0] nb;
        case (mode)
            MODE_QPSK:   nb = 3'd2;
            MODE_8PSK:   nb = 3'd3;
            MODE_16APSK: nb = 3'd4;
            MODE_32APSK: nb = 3'd5;
            MODE_64APSK: nb = 3'd6;
            default:     nb = 3'd2;
        endcase
        return nb;
    endfunction

endpackage

// File: rtl/demap_frame_ctrl.sv
// Frame controller for the APSK demapper: accepts a frame config, issues len
// symbols, collects len LLR sets and guards the drain phase with a watchdog.
module demap_frame_ctrl
    import demap_pkg::*;
#(
    parameter int PIPE_LAT = 6,
    parameter int WD_CYC   = PIPE_LAT + 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [2:0]  cfg_mode,
    input  logic [11:0] cfg_len,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        dm_en,
    output logic [2:0]  dm_mode,
    input  logic        dm_valid,
    output logic        o_llr_valid,
    output logic        o_llr_last,
    output logic [2:0]  o_nbits,
    output logic        busy,
    output logic        err_cfg,
    output logic        err_sync,
    output logic        err_timeout
);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_RUN   = ST_RUN;
    localparam logic [1:0] S_DRAIN = ST_DRAIN;

    localparam int              WD_W     = $clog2(WD_CYC + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(WD_CYC);
    localparam logic [WD_W-1:0] WD_ONE   = WD_W'(1);
    localparam logic [WD_W-1:0] WD_ZERO  = WD_W'(0);

    logic [1:0]      state_q, state_d;
    logic [2:0]      mode_q, mode_d;
    logic [11:0]     len_q, len_d;
    logic [11:0]     issued_q, issued_d;
    logic [11:0]     recv_q, recv_d;
    logic [3:0]      inflight_q, inflight_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            err_cfg_q, err_sync_q, err_to_q;

    logic in_idle_s, in_run_s, in_drain_s;
    logic cfg_bad_s, cfg_take_s;
    logic accept_s, spurious_s, last_s, wd_fire_s, frame_end_s;

    assign in_idle_s  = (state_q == S_IDLE);
    assign in_run_s   = (state_q == S_RUN);
    assign in_drain_s = (state_q == S_DRAIN);

    // Handshakes are held low while reset is asserted, whatever the state.
    assign cfg_ready = rst_n & in_idle_s;
    assign s_ready   = rst_n & in_run_s;
    assign dm_en     = s_valid & s_ready;

    assign cfg_bad_s  = cfg_valid & cfg_ready & ((cfg_mode > MODE_MAX) | (cfg_len == 12'd0));
    assign cfg_take_s = cfg_valid & cfg_ready & ~cfg_bad_s;

    // A result is only frame-owned if a symbol is actually outstanding.
    assign accept_s    = rst_n & dm_valid & (inflight_q != 4'd0);
    assign spurious_s  = dm_valid & (inflight_q == 4'd0);
    assign last_s      = accept_s & ((recv_q + 12'd1) == len_q);
    assign wd_fire_s   = in_drain_s & ~dm_valid & ((wd_q + WD_ONE) == WD_LIMIT);
    assign frame_end_s = last_s | wd_fire_s;

    assign o_llr_valid = accept_s;
    assign o_llr_last  = last_s;
    assign dm_mode     = mode_q;
    assign o_nbits     = bits_per_mode(mode_q);
    assign busy        = in_run_s | in_drain_s;
    assign err_cfg     = err_cfg_q;
    assign err_sync    = err_sync_q;
    assign err_timeout = err_to_q;

    // Next-state and counter update; frame completion or timeout wins over everything.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        len_d      = len_q;
        issued_d   = issued_q;
        recv_d     = recv_q;
        inflight_d = inflight_q;
        wd_d       = wd_q;
        if (frame_end_s) begin
            state_d    = S_IDLE;
            issued_d   = 12'd0;
            recv_d     = 12'd0;
            inflight_d = 4'd0;
            wd_d       = WD_ZERO;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cfg_take_s) begin
                        state_d = S_RUN;
                        mode_d  = cfg_mode;
                        len_d   = cfg_len;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_RUN: begin
                    if (dm_en && ((issued_q + 12'd1) == len_q)) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_RUN;
                    end
                end
                S_DRAIN: state_d = S_DRAIN;
                default: state_d = S_IDLE;
            endcase
            if (dm_en) begin
                issued_d = issued_q + 12'd1;
            end else begin
                issued_d = issued_q;
            end
            if (accept_s) begin
                recv_d = recv_q + 12'd1;
            end else begin
                recv_d = recv_q;
            end
            if (dm_en && !accept_s) begin
                inflight_d = inflight_q + 4'd1;
            end else if (!dm_en && accept_s) begin
                inflight_d = inflight_q - 4'd1;
            end else begin
                inflight_d = inflight_q;
            end
            // The watchdog only measures consecutive silent cycles inside DRAIN.
            if (in_drain_s && !dm_valid) begin
                wd_d = wd_q + WD_ONE;
            end else begin
                wd_d = WD_ZERO;
            end
        end
    end

    // State, counters and error pulse registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            mode_q     <= 3'd0;
            len_q      <= 12'd0;
            issued_q   <= 12'd0;
            recv_q     <= 12'd0;
            inflight_q <= 4'd0;
            wd_q       <= WD_ZERO;
            err_cfg_q  <= 1'b0;
            err_sync_q <= 1'b0;
            err_to_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            recv_q     <= recv_d;
            inflight_q <= inflight_d;
            wd_q       <= wd_d;
            err_cfg_q  <= cfg_bad_s;
            err_sync_q <= spurious_s;
            err_to_q   <= wd_fire_s;
        end
    end

endmodule

// File: tb/tb_demap_frame_ctrl.sv
// Directed bench for demap_frame_ctrl: a table of frame configs plus hand-built
// sequences for spurious results, drain timeout and mid-frame reset.
module tb_demap_frame_ctrl;

    localparam int PL = 6;
    localparam int WD = PL + 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [2:0]  cfg_mode = 3'd0;
    logic [11:0] cfg_len = 12'd0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        dm_en;
    logic [2:0]  dm_mode;
    logic        dm_valid;
    logic        o_llr_valid;
    logic        o_llr_last;
    logic [2:0]  o_nbits;
    logic        busy;
    logic        err_cfg;
    logic        err_sync;
    logic        err_timeout;

    logic          inject = 1'b0;
    logic          withhold = 1'b0;
    logic [PL-1:0] pipe_q = '0;

    demap_frame_ctrl #(.PIPE_LAT(PL)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_mode(cfg_mode), .cfg_len(cfg_len),
        .s_valid(s_valid), .s_ready(s_ready),
        .dm_en(dm_en), .dm_mode(dm_mode), .dm_valid(dm_valid),
        .o_llr_valid(o_llr_valid), .o_llr_last(o_llr_last), .o_nbits(o_nbits),
        .busy(busy), .err_cfg(err_cfg), .err_sync(err_sync), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // Demapper stand-in: fixed PL-cycle delay from dm_en to dm_valid.
    always @(posedge clk) pipe_q <= {pipe_q[PL-2:0], dm_en};
    assign dm_valid = (pipe_q[PL-1] & ~withhold) | inject;

    typedef struct {
        logic [2:0]  mode;
        logic [11:0] len;
        int          gap;
        bit          accept;
        int          nbits;
        int          span;
        int          max_infl;
    } vec_t;

    vec_t vecs[7];

    int n_total = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_en, n_llr, n_last, last_ok, nbits_bad, infl, max_infl;
    int n_errcfg, n_errsync, n_errto, to_cyc, to_busy, last_llr_cyc;
    int first_en, last_en, busy_seen, post_ready, post_done, prev_last;
    int cur_nbits, cur_len;
    logic [2:0] exp_mode;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_stats();
        n_en = 0; n_llr = 0; n_last = 0; last_ok = 0; nbits_bad = 0; infl = 0; max_infl = 0;
        n_errcfg = 0; n_errsync = 0; n_errto = 0; to_cyc = -1; to_busy = -1; last_llr_cyc = -1;
        first_en = -1; last_en = -1; busy_seen = 0; post_ready = 0; post_done = 0; prev_last = 0;
    endtask

    // One cycle: sample on the falling edge, then return just after the rising edge.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (dm_en) begin
            n_en++;
            infl++;
            if (first_en < 0) first_en = cyc;
            last_en = cyc;
        end
        if (o_llr_valid) begin
            n_llr++;
            infl--;
            last_llr_cyc = cyc;
            if (o_nbits != 3'(cur_nbits)) nbits_bad++;
        end
        if (o_llr_last) begin
            n_last++;
            if (o_llr_valid && n_llr == cur_len) last_ok++;
        end
        if (infl > max_infl) max_infl = infl;
        if (err_cfg) n_errcfg++;
        if (err_sync) n_errsync++;
        if (err_timeout) begin
            n_errto++;
            to_cyc = cyc;
            to_busy = int'(busy);
        end
        if (busy) busy_seen = 1;
        if (prev_last != 0) begin
            post_ready = int'(cfg_ready && !busy);
            post_done = 1;
        end
        prev_last = int'(o_llr_last);
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input vec_t v, input bit wh, input string tag);
        int ph;
        bit done;
        for (int k = 0; k < 20 && !cfg_ready; k++) tick();
        clear_stats();
        cur_nbits = v.nbits;
        cur_len = int'(v.len);
        cfg_valid = 1'b1;
        cfg_mode = v.mode;
        cfg_len = v.len;
        tick();
        cfg_valid = 1'b0;
        if (v.accept) begin
            ph = 0;
            done = 1'b0;
            for (int k = 0; k < 400 && !done; k++) begin
                s_valid = (ph == 0) && (n_en < cur_len);
                ph = (ph == v.gap) ? 0 : ph + 1;
                withhold = wh && (n_llr >= 1);
                tick();
                done = (post_done != 0) || (n_errto > 0);
            end
            s_valid = 1'b0;
            withhold = 1'b0;
            check({tag, "_done"}, int'(done), 1);
        end else begin
            repeat (4) tick();
        end
    endtask

    initial begin
        vec_t v;
        vecs[0] = '{mode: 3'd4, len: 12'd3, gap: 0, accept: 1'b1, nbits: 6, span: 2, max_infl: 3};
        vecs[1] = '{mode: 3'd6, len: 12'd5, gap: 0, accept: 1'b0, nbits: 0, span: 0, max_infl: 0};
        vecs[2] = '{mode: 3'd2, len: 12'd0, gap: 0, accept: 1'b0, nbits: 0, span: 0, max_infl: 0};
        vecs[3] = '{mode: 3'd2, len: 12'd4, gap: 2, accept: 1'b1, nbits: 4, span: 9, max_infl: 2};
        vecs[4] = '{mode: 3'd7, len: 12'd1, gap: 0, accept: 1'b0, nbits: 0, span: 0, max_infl: 0};
        vecs[5] = '{mode: 3'd1, len: 12'd8, gap: 0, accept: 1'b1, nbits: 3, span: 7, max_infl: 6};
        vecs[6] = '{mode: 3'd3, len: 12'd2, gap: 1, accept: 1'b1, nbits: 5, span: 2, max_infl: 2};

        // Reset state, with s_valid high to show dm_en is still forced low.
        s_valid = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("rst_handshake", int'({cfg_ready, s_ready, dm_en}), 0);
        check("rst_busy_mode", int'({busy, dm_mode}), 0);
        check("rst_nbits", int'(o_nbits), 2);
        check("rst_outputs", int'({o_llr_valid, o_llr_last, err_cfg, err_sync, err_timeout}), 0);
        s_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        check("rel_cfg_ready", int'(cfg_ready), 1);
        @(posedge clk);
        #1;
        exp_mode = 3'd0;

        for (int i = 0; i < 7; i++) begin
            v = vecs[i];
            run_frame(v, 1'b0, $sformatf("v%0d", i));
            if (v.accept) begin
                exp_mode = v.mode;
                check($sformatf("v%0d_n_en", i), n_en, int'(v.len));
                check($sformatf("v%0d_en_span", i), last_en - first_en, v.span);
                check($sformatf("v%0d_n_llr", i), n_llr, int'(v.len));
                check($sformatf("v%0d_last_on_final", i), last_ok, 1);
                check($sformatf("v%0d_n_last", i), n_last, 1);
                check($sformatf("v%0d_nbits_bad", i), nbits_bad, 0);
                check($sformatf("v%0d_max_infl", i), max_infl, v.max_infl);
                check($sformatf("v%0d_ready_after_last", i), post_ready, 1);
                check($sformatf("v%0d_errs", i), n_errcfg + n_errsync + n_errto, 0);
            end else begin
                check($sformatf("v%0d_err_cfg_cycles", i), n_errcfg, 1);
                check($sformatf("v%0d_busy_seen", i), busy_seen, 0);
                check($sformatf("v%0d_n_en", i), n_en, 0);
            end
            check($sformatf("v%0d_dm_mode", i), int'(dm_mode), int'(exp_mode));
        end

        // Spurious demapper result while idle.
        clear_stats();
        inject = 1'b1;
        tick();
        inject = 1'b0;
        repeat (3) tick();
        check("spur_llr_valid", n_llr, 0);
        check("spur_err_sync", n_errsync, 1);
        check("spur_busy", busy_seen, 0);

        // Second result never arrives: watchdog must fire WD silent cycles later.
        v = '{mode: 3'd1, len: 12'd2, gap: 0, accept: 1'b1, nbits: 3, span: 1, max_infl: 2};
        run_frame(v, 1'b1, "wd");
        exp_mode = 3'd1;
        check("wd_n_llr", n_llr, 1);
        check("wd_err_timeout", n_errto, 1);
        check("wd_delay", to_cyc - last_llr_cyc, WD + 1);
        check("wd_idle_at_pulse", to_busy, 0);
        check("wd_no_last", n_last, 0);
        repeat (2) tick();
        check("wd_cfg_ready", int'(cfg_ready), 1);

        // One-cycle reset in the middle of a long frame.
        clear_stats();
        cfg_valid = 1'b1;
        cfg_mode = 3'd3;
        cfg_len = 12'd100;
        tick();
        cfg_valid = 1'b0;
        s_valid = 1'b1;
        repeat (10) tick();
        check("mid_n_en", n_en, 10);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_comb", int'({cfg_ready, s_ready, dm_en, o_llr_valid, o_llr_last}), 0);
        @(posedge clk);
        #1;
        check("mid_rst_handshake", int'({cfg_ready, s_ready, dm_en}), 0);
        check("mid_rst_state", int'({busy, dm_mode}), 0);
        check("mid_rst_nbits", int'(o_nbits), 2);
        check("mid_rst_pulses", int'({o_llr_valid, o_llr_last, err_cfg, err_sync, err_timeout}), 0);
        rst_n = 1'b1;
        s_valid = 1'b0;
        #1;
        check("mid_rel_cfg_ready", int'(cfg_ready), 1);
        clear_stats();
        repeat (8) tick();
        check("mid_orphan_err_sync", n_errsync, PL - 1);
        check("mid_orphan_llr", n_llr, 0);
        check("mid_orphan_other", n_errcfg + n_errto + busy_seen, 0);

        v = '{mode: 3'd0, len: 12'd1, gap: 0, accept: 1'b1, nbits: 2, span: 0, max_infl: 1};
        run_frame(v, 1'b0, "post_rst");
        check("post_rst_n_llr", n_llr, 1);
        check("post_rst_last", last_ok, 1);
        check("post_rst_nbits_bad", nbits_bad, 0);
        check("post_rst_ready", post_ready, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench did not finish");
    end

endmodule
